// File: rtl/debug_dump_unit.sv
// Debug dump engine: streams the halted PC, the register file and the data memory
// as a little-endian byte stream toward a UART transmitter.
module debug_dump_unit #(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_REG       = 5,
  parameter int unsigned NB_MEM_ADDR  = 4,
  parameter int unsigned NB_MEM_WIDTH = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [NB_DATA-1:0]      i_pc,
  output logic [NB_REG-1:0]       o_reg_addr,
  input  logic [NB_DATA-1:0]      i_reg_data,
  output logic [NB_MEM_ADDR-1:0]  o_mem_addr,
  input  logic [NB_DATA-1:0]      i_mem_data,
  output logic [NB_MEM_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned BytesPerWord = NB_DATA / NB_MEM_WIDTH;
  localparam int unsigned CntW = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam int unsigned IdxW = (NB_REG > NB_MEM_ADDR) ? NB_REG : NB_MEM_ADDR;
  localparam logic [IdxW-1:0] RegLast  = IdxW'((2 ** NB_REG) - 1);
  localparam logic [IdxW-1:0] MemLast  = IdxW'((2 ** NB_MEM_ADDR) - 1);
  localparam logic [CntW-1:0] ByteLast = CntW'(BytesPerWord - 1);

  typedef enum logic [2:0] {StIdle, StSend, StFetch, StLoad, StDone} state_e;
  // Phase names the source of the next word to fetch; PhEnd means nothing is left.
  typedef enum logic [1:0] {PhReg, PhMem, PhEnd} phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [NB_DATA-1:0] buf_q, buf_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      phase_q <= PhEnd;
      buf_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StSend;
          phase_d = PhReg;
          buf_d   = i_pc;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StSend: begin
        if (i_tx_ready) begin
          buf_d = buf_q >> NB_MEM_WIDTH;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == ByteLast) begin
            cnt_d   = '0;
            state_d = (phase_q == PhEnd) ? StDone : StFetch;
          end
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        state_d = StSend;
        if (phase_q == PhReg) begin
          buf_d = i_reg_data;
          if (idx_q == RegLast) begin
            idx_d   = '0;
            phase_d = PhMem;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          buf_d = i_mem_data;
          // Last memory word: hold the index rather than wrapping.
          if (idx_q == MemLast) phase_d = PhEnd;
          else                  idx_d   = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        buf_d   = '0;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_tx_valid = (state_q == StSend);
    o_tx_data  = o_tx_valid ? buf_q[NB_MEM_WIDTH-1:0] : '0;
    o_busy     = (state_q != StIdle);
    o_done     = (state_q == StDone);
    o_reg_addr = (phase_q == PhReg) ? idx_q[NB_REG-1:0] : '0;
    o_mem_addr = (phase_q == PhMem) ? idx_q[NB_MEM_ADDR-1:0] : '0;
  end

endmodule

// File: doc/debug_dump_unit.md
DEBUG_DUMP_UNIT -- requirements
Module: debug_dump_unit

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning the width of the PC, register and data-memory words.
REQ-002 The block SHALL have parameter NB_REG, default 5, meaning the register-file address width (32 registers).
REQ-003 The block SHALL have parameter NB_MEM_ADDR, default 4, meaning the data-memory word address width; N_MEM_WORDS = 2**NB_MEM_ADDR.
REQ-004 The block SHALL have parameter NB_MEM_WIDTH, default 8, meaning the output byte width.
REQ-005 The block SHALL have port i_clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_reset, input, 1 bit; reset is synchronous and active-high.
REQ-007 The block SHALL have port i_start, input, 1 bit, a dump request sampled in IDLE only.
REQ-008 The block SHALL have port i_pc, input, NB_DATA bits, the halted PC value.
REQ-009 The block SHALL have port o_reg_addr, output, NB_REG bits, the register-file read address.
REQ-010 The block SHALL have port i_reg_data, input, NB_DATA bits, the register data, valid one cycle after o_reg_addr.
REQ-011 The block SHALL have port o_mem_addr, output, NB_MEM_ADDR bits, the data-memory word read address.
REQ-012 The block SHALL have port i_mem_data, input, NB_DATA bits, the memory data, valid one cycle after o_mem_addr.
REQ-013 The block SHALL have ports o_tx_data (output, NB_MEM_WIDTH bits), o_tx_valid (output, 1 bit) and i_tx_ready (input, 1 bit), forming the byte stream toward the UART transmitter.
REQ-014 The block SHALL have port o_busy, output, 1 bit, high in every state except IDLE.
REQ-015 The block SHALL have port o_done, output, 1 bit, a one-cycle pulse at the end of a dump.

Function
REQ-016 The block SHALL implement the FSM states IDLE, SEND, FETCH, LOAD and DONE.
REQ-017 In IDLE with i_start=1, the block SHALL latch i_pc into a NB_DATA-bit word buffer, clear the byte counter, and go to SEND.
REQ-018 In SEND, the block SHALL assert o_tx_valid=1 and drive o_tx_data from buffer[7:0].
REQ-019 A byte transfer SHALL occur only on an edge with o_tx_valid=1 and i_tx_ready=1; on transfer, the buffer shifts right by 8 and the byte counter increments.
REQ-020 While o_tx_valid=1 and i_tx_ready=0, the block SHALL hold o_tx_data and o_tx_valid stable.
REQ-021 Each word SHALL be sent as 4 bytes, least-significant byte first.
REQ-022 On transfer of the 4th byte, the block SHALL go to FETCH if words remain, otherwise to DONE.
REQ-023 Dump order SHALL be PC, then registers 0..31, then memory words 0..N_MEM_WORDS-1, for a total of 4*(33+N_MEM_WORDS) bytes.
REQ-024 A word index counter SHALL drive o_reg_addr during the register phase and o_mem_addr during the memory phase; idle addresses are held at 0.
REQ-025 FETCH SHALL last one cycle with the address stable; in LOAD, the block SHALL capture i_reg_data or i_mem_data into the buffer, advance the index, and go to SEND.
REQ-026 The index SHALL wrap from 31 to 0 on the register-to-memory transition; the memory phase ends after index N_MEM_WORDS-1, with no wrap beyond it.
REQ-027 o_tx_valid SHALL be 0 in IDLE, FETCH, LOAD and DONE, giving a 2-cycle valid gap between words.
REQ-028 DONE SHALL last one cycle, drive o_done=1, and return to IDLE.
REQ-029 i_start SHALL be ignored outside IDLE; i_start asserted in the same cycle that DONE returns to IDLE SHALL NOT start a dump (it is sampled in IDLE only).
REQ-030 Latency SHALL be as follows: i_start sampled at edge k gives o_tx_valid=1 with o_tx_data=i_pc[7:0] in the cycle after edge k.

Reset
REQ-031 On i_reset=1 at an edge, the block SHALL enter IDLE with o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0, o_reg_addr=0, o_mem_addr=0, buffer=0 and counters=0.
REQ-032 Reset SHALL take priority over i_start and over any in-flight transfer; an aborted dump SHALL NOT resume.

Verification
REQ-033 Scenario: i_pc=0x00000040, i_start pulse, i_tx_ready=1 -> bytes 0x40,0x00,0x00,0x00, then FETCH/LOAD gap, then o_reg_addr=0 requested.
REQ-034 Scenario: register model reg[n]=0x11223300+n and memory model mem[n]=0xA0000000+n, with ready always high -> all 4*(33+16)=196 bytes match in order, and o_done pulses in cycle 293, counting the first valid cycle as 1.
REQ-035 Scenario: i_tx_ready toggling pseudo-randomly -> o_tx_data is unchanged across every stalled cycle, with no byte lost or duplicated.
REQ-036 Scenario: i_start pulsed again mid-dump -> ignored, and the byte count is still 196.
REQ-037 Scenario: i_reset asserted during the memory phase -> next cycle all outputs are 0 and o_busy=0; a fresh i_start then restarts from the PC bytes.
REQ-038 Scenario: i_start held high continuously -> back-to-back dumps separated by one DONE cycle plus one IDLE cycle.
